// File: rtl/hs32_mem_arb.sv
// Purpose: arbitrates NCH requester channels onto one registered external valid/ready memory bus.
// Latency: req -> valid 1 cycle, ready -> rdy 1 cycle, then one idle cycle (3 cycles per transfer best case).
// Backpressure: external ready may stall a transfer indefinitely; requesters hold their request until rdy.
module hs32_mem_arb #(
   parameter int NCH = 2,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int RR  = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    rw_ch,
   input  logic [NCH*AW-1:0] addr_ch,
   input  logic [NCH*DW-1:0] dtw_ch,
   output logic [NCH*DW-1:0] dtr_ch,
   output logic [NCH-1:0]    rdy,
   output logic [NCH-1:0]    gnt,
   output logic [AW-1:0]     addr,
   output logic              rw,
   output logic [DW-1:0]     dout,
   input  logic [DW-1:0]     din,
   output logic              valid,
   input  logic              ready
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nxt;

   // Most recently granted channel; the round-robin search starts just above it.
   logic [IW-1:0]  last;

   logic [IW-1:0]  win;
   logic [IW-1:0]  lo_idx;
   logic [IW-1:0]  hi_idx;
   logic           hi_found;
   logic [NCH-1:0] win_oh;
   logic [AW-1:0]  sel_addr;
   logic [DW-1:0]  sel_dtw;
   logic           sel_rw;

   logic           any_req;
   logic           do_grant;
   logic           do_done;
   logic           do_release;

   assign any_req = |req;

   // Winner selection: lowest requester overall, or (round-robin) lowest requester above last,
   // wrapping to the lowest requester overall when nothing above last is asking.
   always_comb begin
      lo_idx   = '0;
      hi_idx   = '0;
      hi_found = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_idx = IW'(i);
         end
         if (req[i] && (i > int'(last))) begin
            hi_idx   = IW'(i);
            hi_found = 1'b1;
         end
      end
      if ((RR != 0) && hi_found) begin
         win = hi_idx;
      end else begin
         win = lo_idx;
      end
   end

   // Route the winning channel's request fields towards the bus registers.
   always_comb begin
      sel_addr = '0;
      sel_dtw  = '0;
      sel_rw   = 1'b0;
      win_oh   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (win == IW'(i)) begin
            sel_addr  = addr_ch[i*AW +: AW];
            sel_dtw   = dtw_ch[i*DW +: DW];
            sel_rw    = rw_ch[i];
            win_oh[i] = 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state and per-phase strobes; req is only looked at in IDLE, ready only in BUS.
   always_comb begin
      state_nxt  = state;
      do_grant   = 1'b0;
      do_done    = 1'b0;
      do_release = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               do_grant  = 1'b1;
               state_nxt = BUS;
            end
         end
         BUS: begin
            if (ready) begin
               do_done   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: begin
            do_release = 1'b1;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // External bus registers and ownership: captured on grant, frozen through BUS and RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr  <= '0;
         rw    <= 1'b0;
         dout  <= '0;
         valid <= 1'b0;
         gnt   <= '0;
         last  <= IW'(NCH - 1);
      end else begin
         if (do_grant) begin
            addr  <= sel_addr;
            rw    <= sel_rw;
            dout  <= sel_dtw;
            valid <= 1'b1;
            gnt   <= win_oh;
            last  <= win;
         end
         if (do_done) begin
            valid <= 1'b0;
         end
         if (do_release) begin
            gnt <= '0;
         end
      end
   end

   // Completion pulse to the owner and read-data return; dtr_ch of a channel only moves on its own read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy    <= '0;
         dtr_ch <= '0;
      end else begin
         rdy <= do_done ? gnt : '0;
         if (do_done && !rw) begin
            for (int i = 0; i < NCH; i++) begin
               if (gnt[i]) begin
                  dtr_ch[i*DW +: DW] <= din;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Bench for hs32_mem_arb: a 2-channel fixed-priority instance and a 4-channel round-robin instance.
// Inputs are driven on the falling edge, outputs sampled on the falling edge before driving.
// Expected values come from a vector table, hand sequences and a transaction-level model.
module tb_hs32_mem_arb;

   logic clk;
   logic reset;

   // Instance A: NCH=2, fixed priority
   logic [1:0]  req_a, rw_ch_a, rdy_a, gnt_a;
   logic [63:0] addr_ch_a, dtw_ch_a, dtr_ch_a;
   logic [31:0] addr_a, dout_a, din_a;
   logic        rw_a, valid_a, ready_a;

   // Instance B: NCH=4, round-robin
   logic [3:0]   req_b, rw_ch_b, rdy_b, gnt_b;
   logic [127:0] addr_ch_b, dtw_ch_b, dtr_ch_b;
   logic [31:0]  addr_b, dout_b, din_b;
   logic         rw_b, valid_b, ready_b;

   int errors = 0;
   int checks = 0;

   hs32_mem_arb #(.NCH(2), .AW(32), .DW(32), .RR(0)) u_fp (
      .clk(clk), .reset(reset), .req(req_a), .rw_ch(rw_ch_a), .addr_ch(addr_ch_a),
      .dtw_ch(dtw_ch_a), .dtr_ch(dtr_ch_a), .rdy(rdy_a), .gnt(gnt_a), .addr(addr_a),
      .rw(rw_a), .dout(dout_a), .din(din_a), .valid(valid_a), .ready(ready_a)
   );

   hs32_mem_arb #(.NCH(4), .AW(32), .DW(32), .RR(1)) u_rr (
      .clk(clk), .reset(reset), .req(req_b), .rw_ch(rw_ch_b), .addr_ch(addr_ch_b),
      .dtw_ch(dtw_ch_b), .dtr_ch(dtr_ch_b), .rdy(rdy_b), .gnt(gnt_b), .addr(addr_b),
      .rw(rw_b), .dout(dout_b), .din(din_b), .valid(valid_b), .ready(ready_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  req;
      logic [1:0]  rw;
      logic [31:0] a0, a1, d0, d1, din;
      int          waits;
      logic [1:0]  e_gnt;
      logic [31:0] e_addr;
      logic        e_rw;
      logic [31:0] e_dout, e_dtr0, e_dtr1;
   } vec_a_t;

   vec_a_t vt[6];

   // Reference model state for instance B
   logic [31:0] exp_dtr[4];
   int          model_last;
   logic [31:0] ra[4], rdw[4];
   logic [3:0]  rq;
   logic [1:0]  mi;
   logic        found;
   int          mc, waits_m;
   logic [31:0] ea, ed, dsv;
   logic        er;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic pack_b();
      addr_ch_b = {ra[3], ra[2], ra[1], ra[0]};
      dtw_ch_b  = {rdw[3], rdw[2], rdw[1], rdw[0]};
   endtask

   // One instance-A transaction from a table record; called at a falling edge with A idle.
   task automatic run_a(input vec_a_t v, input string tag);
      req_a     = v.req;
      rw_ch_a   = v.rw;
      addr_ch_a = {v.a1, v.a0};
      dtw_ch_a  = {v.d1, v.d0};
      din_a     = v.din;
      ready_a   = 1'b0;
      @(negedge clk);
      for (int w = 0; w <= v.waits; w++) begin
         chk({tag, " valid"}, 32'(valid_a), 32'd1);
         chk({tag, " gnt"},   32'(gnt_a),   32'(v.e_gnt));
         chk({tag, " addr"},  addr_a,       v.e_addr);
         chk({tag, " rw"},    32'(rw_a),    32'(v.e_rw));
         chk({tag, " dout"},  dout_a,       v.e_dout);
         chk({tag, " rdy early"}, 32'(rdy_a), 32'd0);
         ready_a = (w == v.waits);
         @(negedge clk);
      end
      ready_a = 1'b0;
      chk({tag, " rdy"},      32'(rdy_a),   32'(v.e_gnt));
      chk({tag, " valid lo"}, 32'(valid_a), 32'd0);
      chk({tag, " gnt resp"}, 32'(gnt_a),   32'(v.e_gnt));
      chk({tag, " dtr0"},     dtr_ch_a[31:0],  v.e_dtr0);
      chk({tag, " dtr1"},     dtr_ch_a[63:32], v.e_dtr1);
      req_a = 2'b00;
      @(negedge clk);
      chk({tag, " idle gnt"}, 32'(gnt_a), 32'd0);
      chk({tag, " idle rdy"}, 32'(rdy_a), 32'd0);
   endtask

   // One immediate-ready read on instance B with a known expected owner; nxt is the req for the next IDLE.
   task automatic b_run(input logic [3:0] eg, input logic [3:0] nxt, input string tag);
      logic [31:0] dv;
      @(negedge clk);
      chk({tag, " gnt"},   32'(gnt_b),   32'(eg));
      chk({tag, " valid"}, 32'(valid_b), 32'd1);
      dv      = $urandom;
      din_b   = dv;
      ready_b = 1'b1;
      @(negedge clk);
      ready_b = 1'b0;
      chk({tag, " rdy"}, 32'(rdy_b), 32'(eg));
      for (int c = 0; c < 4; c++) begin
         if (eg[c]) begin
            exp_dtr[c] = dv;
            model_last = c;
            chk({tag, " dtr"}, dtr_ch_b[c*32 +: 32], dv);
         end
      end
      req_b = nxt;
      @(negedge clk);
      chk({tag, " idle gnt"},   32'(gnt_b),   32'd0);
      chk({tag, " idle valid"}, 32'(valid_b), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      req_a = '0; rw_ch_a = '0; addr_ch_a = '0; dtw_ch_a = '0; din_a = '0; ready_a = 1'b0;
      req_b = '0; rw_ch_b = '0; addr_ch_b = '0; dtw_ch_b = '0; din_b = '0; ready_b = 1'b0;
      for (int c = 0; c < 4; c++) begin
         exp_dtr[c] = '0;
         ra[c]      = '0;
         rdw[c]     = '0;
      end
      model_last = 3;

      vt[0] = '{req:2'b01, rw:2'b00, a0:32'h100, a1:32'h999, d0:32'h0, d1:32'h5, din:32'hDEADBEEF,
                waits:0, e_gnt:2'b01, e_addr:32'h100, e_rw:1'b0, e_dout:32'h0,
                e_dtr0:32'hDEADBEEF, e_dtr1:32'h0};
      vt[1] = '{req:2'b10, rw:2'b10, a0:32'h300, a1:32'h200, d0:32'hAAAA, d1:32'h12345678, din:32'hCAFEF00D,
                waits:4, e_gnt:2'b10, e_addr:32'h200, e_rw:1'b1, e_dout:32'h12345678,
                e_dtr0:32'hDEADBEEF, e_dtr1:32'h0};
      vt[2] = '{req:2'b11, rw:2'b00, a0:32'h10, a1:32'h20, d0:32'h1, d1:32'h2, din:32'h11111111,
                waits:1, e_gnt:2'b01, e_addr:32'h10, e_rw:1'b0, e_dout:32'h1,
                e_dtr0:32'h11111111, e_dtr1:32'h0};
      vt[3] = '{req:2'b11, rw:2'b01, a0:32'h40, a1:32'h44, d0:32'h55, d1:32'h66, din:32'h22222222,
                waits:2, e_gnt:2'b01, e_addr:32'h40, e_rw:1'b1, e_dout:32'h55,
                e_dtr0:32'h11111111, e_dtr1:32'h0};
      vt[4] = '{req:2'b10, rw:2'b00, a0:32'h48, a1:32'h204, d0:32'h3, d1:32'h7, din:32'h33333333,
                waits:0, e_gnt:2'b10, e_addr:32'h204, e_rw:1'b0, e_dout:32'h7,
                e_dtr0:32'h11111111, e_dtr1:32'h33333333};
      vt[5] = '{req:2'b10, rw:2'b11, a0:32'h4C, a1:32'h208, d0:32'h8, d1:32'h9, din:32'h44444444,
                waits:1, e_gnt:2'b10, e_addr:32'h208, e_rw:1'b1, e_dout:32'h9,
                e_dtr0:32'h11111111, e_dtr1:32'h33333333};

      #2 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      // Reset state of both instances
      chk("rst valid_a", 32'(valid_a), 32'd0);
      chk("rst gnt_a",   32'(gnt_a),   32'd0);
      chk("rst rdy_a",   32'(rdy_a),   32'd0);
      chk("rst addr_a",  addr_a,       32'd0);
      chk("rst dout_a",  dout_a,       32'd0);
      chk("rst rw_a",    32'(rw_a),    32'd0);
      chk("rst dtr_a0",  dtr_ch_a[31:0],  32'd0);
      chk("rst dtr_a1",  dtr_ch_a[63:32], 32'd0);
      chk("rst valid_b", 32'(valid_b), 32'd0);
      chk("rst gnt_b",   32'(gnt_b),   32'd0);
      chk("rst rdy_b",   32'(rdy_b),   32'd0);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("rst dtr_b%0d", c), dtr_ch_b[c*32 +: 32], 32'd0);
      end
      reset = 1'b1;

      // Table-driven transactions on the fixed-priority instance
      for (int i = 0; i < 6; i++) begin
         run_a(vt[i], $sformatf("vec%0d", i));
      end

      // Idle with req low: ready is ignored, bus fields hold, strobes stay low
      req_a   = 2'b00;
      ready_a = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("idle valid", 32'(valid_a), 32'd0);
         chk("idle gnt",   32'(gnt_a),   32'd0);
         chk("idle rdy",   32'(rdy_a),   32'd0);
         chk("idle addr hold", addr_a,   32'h208);
         chk("idle rw hold",   32'(rw_a), 32'd1);
      end
      ready_a = 1'b0;

      // Fixed priority with both requests held, and back-to-back reissue by channel 0
      @(negedge clk);
      req_a     = 2'b11;
      rw_ch_a   = 2'b00;
      addr_ch_a = {32'h2000, 32'h1000};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("fp valid", 32'(valid_a), 32'd1);
         chk("fp gnt",   32'(gnt_a),   32'd1);
         chk("fp addr",  addr_a,       32'h1000);
         ready_a = 1'b1;
         din_a   = 32'h5A5A0000 + 32'(k);
         @(negedge clk);
         ready_a = 1'b0;
         chk("fp rdy",  32'(rdy_a), 32'd1);
         chk("fp dtr0", dtr_ch_a[31:0], 32'h5A5A0000 + 32'(k));
         if (k == 2) req_a = 2'b00;
         @(negedge clk);
         chk("b2b gap valid", 32'(valid_a), 32'd0);
         chk("b2b gap gnt",   32'(gnt_a),   32'd0);
      end
      chk("fp dtr1 kept", dtr_ch_a[63:32], 32'h33333333);

      // Mid-transaction reset on the round-robin instance (channel 2 owns the bus)
      ra[2] = 32'h7700;
      pack_b();
      req_b   = 4'b0100;
      rw_ch_b = 4'b0000;
      @(negedge clk);
      chk("pre-rst gnt",   32'(gnt_b),   32'h4);
      chk("pre-rst valid", 32'(valid_b), 32'd1);
      @(negedge clk);
      chk("pre-rst hold", addr_b, 32'h7700);
      #2 reset = 1'b0;
      #1;
      chk("async rst valid", 32'(valid_b), 32'd0);
      chk("async rst gnt",   32'(gnt_b),   32'd0);
      chk("async rst rdy",   32'(rdy_b),   32'd0);
      chk("async rst addr",  addr_b,       32'd0);
      chk("async rst dtr_a", dtr_ch_a[31:0], 32'd0);
      for (int c = 0; c < 4; c++) exp_dtr[c] = '0;
      @(negedge clk);
      reset = 1'b1;
      req_b = 4'b1111;

      // Round-robin rotation, then alternation between channels 1 and 3
      b_run(4'b0001, 4'b1111, "rr0");
      b_run(4'b0010, 4'b1111, "rr1");
      b_run(4'b0100, 4'b1111, "rr2");
      b_run(4'b1000, 4'b1111, "rr3");
      b_run(4'b0001, 4'b1010, "rr4");
      b_run(4'b0010, 4'b1010, "alt0");
      b_run(4'b1000, 4'b1010, "alt1");
      b_run(4'b0010, 4'b1010, "alt2");
      b_run(4'b1000, 4'b0000, "alt3");

      // Randomized transactions against the transaction-level model
      for (int t = 0; t < 60; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            req_b   = 4'b0000;
            ready_b = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rnd gap valid", 32'(valid_b), 32'd0);
            chk("rnd gap gnt",   32'(gnt_b),   32'd0);
            chk("rnd gap rdy",   32'(rdy_b),   32'd0);
            ready_b = 1'b0;
         end
         rq = 4'($urandom_range(1, 15));
         for (int c = 0; c < 4; c++) begin
            ra[c]  = $urandom;
            rdw[c] = $urandom;
         end
         pack_b();
         rw_ch_b = 4'($urandom);
         req_b   = rq;
         ready_b = 1'b0;
         // Winner: first requesting channel after the previous owner, wrapping modulo 4
         found = 1'b0;
         mi    = '0;
         for (int k = 1; k <= 4; k++) begin
            mc = (model_last + k) % 4;
            if (!found && rq[mc[1:0]]) begin
               found = 1'b1;
               mi    = mc[1:0];
            end
         end
         model_last = int'(mi);
         ea = ra[mi];
         ed = rdw[mi];
         er = rw_ch_b[mi];
         waits_m = $urandom_range(0, 3);
         dsv = '0;
         @(negedge clk);
         for (int w = 0; w <= waits_m; w++) begin
            chk("rnd valid", 32'(valid_b), 32'd1);
            chk("rnd gnt",   32'(gnt_b),   32'(4'b0001 << mi));
            chk("rnd addr",  addr_b,       ea);
            chk("rnd rw",    32'(rw_b),    32'(er));
            chk("rnd dout",  dout_b,       ed);
            // Other channels change freely while the owner holds its request
            req_b = 4'($urandom) | (4'b0001 << mi);
            for (int c = 0; c < 4; c++) begin
               if (c != int'(mi)) begin
                  ra[c]  = $urandom;
                  rdw[c] = $urandom;
               end
            end
            pack_b();
            rw_ch_b = (4'($urandom) & ~(4'b0001 << mi)) | (rw_ch_b & (4'b0001 << mi));
            din_b   = $urandom;
            ready_b = (w == waits_m);
            if (w == waits_m) dsv = din_b;
            @(negedge clk);
         end
         if (!er) exp_dtr[mi] = dsv;
         chk("rnd rdy",      32'(rdy_b),   32'(4'b0001 << mi));
         chk("rnd valid lo", 32'(valid_b), 32'd0);
         chk("rnd gnt resp", 32'(gnt_b),   32'(4'b0001 << mi));
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("rnd dtr%0d", c), dtr_ch_b[c*32 +: 32], exp_dtr[c]);
         end
         ready_b = 1'($urandom_range(0, 1));
         req_b   = 4'b0000;
         @(negedge clk);
         chk("rnd idle valid", 32'(valid_b), 32'd0);
         chk("rnd idle gnt",   32'(gnt_b),   32'd0);
         chk("rnd idle rdy",   32'(rdy_b),   32'd0);
         chk("rnd idle addr",  addr_b,       ea);
         ready_b = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hs32_mem_arb.md
Name: hs32_mem_arb

Overview:
Parametrised successor to the fixed two-channel memory arbiter between the CPU pipeline units and the external memory bus. It arbitrates NCH requester channels onto a single registered external valid/ready bus. Arbitration is either fixed-priority or round-robin, selected by a parameter. It sits under hs32_cpu with execute on channel 0 and fetch on channel 1; spare channels are reserved for DMA and debug masters.

Parameters:
NCH, 2, number of requester channels (2..8)
AW, 32, address width
DW, 32, data width
RR, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous reset, active-low (0 = reset)
req  input  NCH  per-channel request, level
rw_ch  input  NCH  per-channel direction, 1 = write
addr_ch  input  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW]
dtw_ch  input  NCH*DW  per-channel write data
dtr_ch  output  NCH*DW  per-channel read data
rdy  output  NCH  per-channel completion pulse
gnt  output  NCH  one-hot current owner; 0 when idle
addr  output  AW  external address
rw  output  1  external direction
dout  output  DW  external write data
din  input  DW  external read data
valid  output  1  external request
ready  input  1  external completion

Behaviour:
- FSM states: IDLE, BUS, RESP. Reset (reset=0, asynchronous) forces:
  - state IDLE
  - addr=0, rw=0, dout=0, valid=0
  - rdy=0, gnt=0, dtr_ch=0
  - round-robin pointer last=NCH-1
- IDLE, req=0: remain in IDLE; all outputs hold their values except valid=0, rdy=0, gnt=0.
- IDLE, req!=0: select winner g.
  - RR=0: g = lowest set index.
  - RR=1: g = first set index searching last+1, last+2, ... modulo NCH. last<=g on grant.
  - Next edge: latch addr/rw/dout from channel g, valid<=1, gnt<=onehot(g), state BUS.
- BUS: addr/rw/dout/valid/gnt held stable regardless of req changes. Extra wait cycles are unbounded.
- BUS, ready=1:
  - Next edge: valid<=0, rdy[g]<=1.
  - If rw=0, dtr_ch[g]<=din. On a write, dtr_ch is unchanged.
  - state RESP.
- RESP: rdy[g]=1 for exactly this one cycle. gnt still = onehot(g). Next edge: rdy<=0, gnt<=0, state IDLE.
- dtr_ch[i] holds its last read value until channel i's next read completes.
- Requester contract: hold req/addr/rw/dtw stable from assertion until it observes rdy. Drop req at the edge ending the rdy cycle, or keep it high to issue a new request. req sampled in IDLE is always treated as a new request.
- Minimum latency: req in cycle 0 → valid in cycle 1 → (ready in cycle 1) → rdy in cycle 2 → IDLE in cycle 3. One transaction per 3 cycles best case.
- A req deasserted before grant is simply not served. A req deasserted during BUS/RESP does not abort the transaction.
- ready while not in BUS is ignored.
- RR=1 starvation bound: a continuously requesting channel is granted within NCH transactions. RR=0 provides no such guarantee.
- Reset asserted mid-transaction (any state): immediate return to reset values. The outstanding external access is abandoned, and no rdy is produced for it.
- NCH=1: the arbiter degenerates to a pass-through register stage; the pointer is unused.

Test Plan:
- Single read: NCH=2, RR=0. req=01, addr_ch[0]=0x100, rw=0; ready=1 in the first valid cycle with din=0xDEADBEEF. Required: valid in cycle 1 with addr=0x100; rdy=01 in cycle 2; dtr_ch[0]=0xDEADBEEF.
- Write with wait states: channel 1 writes 0x12345678 to 0x200; ready held low for 4 cycles. Required:
  - valid/addr/dout/rw=1 stable for 5 cycles;
  - rdy=10 exactly one cycle after ready;
  - dtr_ch[1] unchanged.
- Fixed priority: RR=0, req=11 held continuously. Required: channel 0 granted every transaction; channel 1 never granted while req[0]=1.
- Round-robin: NCH=4, RR=1, req=1111 held. Required: gnt sequence 0001, 0010, 0100, 1000, 0001. With req=1010, the sequence alternates 0010, 1000.
- Mid-transaction reset: reset pulled to 0 during BUS. Required: valid=0, gnt=0, rdy=0 immediately (asynchronous). After release, the first grant under RR=1 goes to channel 0.
- Back-to-back: channel 0 keeps req high through rdy. Required: second valid appears exactly 2 cycles after the first rdy cycle.
